// File: rtl/bnn_pkg.sv
// Shared dimensions and storage types for the BNN input registers.
package bnn_pkg;

   localparam int unsigned IMG_DIM   = 28;
   localparam int unsigned K_DIM     = 3;
   localparam int unsigned N_FILT    = 8;
   localparam int unsigned N_PIX     = IMG_DIM * IMG_DIM;
   localparam int unsigned N_WGT     = N_FILT * K_DIM * K_DIM;
   localparam int unsigned PIX_CNT_W = 10;
   localparam int unsigned WGT_CNT_W = 7;

   typedef logic [IMG_DIM-1:0][IMG_DIM-1:0] pixel_img_t;
   typedef logic [K_DIM-1:0][K_DIM-1:0]     kernel_t;

endpackage

// File: rtl/serial_loader.sv
// Serial-to-parallel store: a saturating bit counter selects, via a one-hot decode,
// which flop captures d_in. Optional count port under REGISTERS_STATUS_EN.
module serial_loader #(
   parameter int unsigned DEPTH = 784,
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             d_in,
   output logic [DEPTH-1:0] data,
`ifdef REGISTERS_STATUS_EN
   output logic [CNT_W-1:0] count,
`endif
   output logic             full
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   logic [DEPTH-1:0] data_q;
   logic [DEPTH-1:0] wr_sel;
   logic [CNT_W-1:0] count_q;
   logic             full_q;
   logic             wr;

   assign wr = en & ~full_q;

   always_comb begin
      wr_sel = '0;
      if (wr) begin
         wr_sel[count_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         data_q <= (data_q & ~wr_sel) | (wr_sel & {DEPTH{d_in}});
         if (wr) begin
            count_q <= count_q + 1'b1;
            // Full on the same edge that captures the last bit; counter then parks at DEPTH.
            if (count_q == LAST) begin
               full_q <= 1'b1;
            end
         end
      end
   end

   assign data = data_q;
   assign full = full_q;
`ifdef REGISTERS_STATUS_EN
   assign count = count_q;
`endif

endmodule

// File: rtl/bnn_registers.sv
// Image and kernel storage filled from two parallel serial streams.
// Optional status outputs (pixel_count, weights_done) under REGISTERS_STATUS_EN.
module bnn_registers
   import bnn_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en_wr,
   input  logic                   d_in_p,
   input  logic                   d_in_w,
   output pixel_img_t             pixels,
   output kernel_t [N_FILT-1:0]   weights,
`ifdef REGISTERS_STATUS_EN
   output logic [PIX_CNT_W-1:0]   pixel_count,
   output logic [0:0]             weights_done,
`endif
   output logic                   load_done
);

   logic [N_PIX-1:0] pix_flat;
   logic [N_WGT-1:0] wgt_flat;
   logic             pix_full;
   logic             wgt_full;
   logic             pix_en;
   logic             wgt_en;

   // Everything freezes once the image is complete; weights also stop at saturation.
   assign pix_en = en_wr & ~pix_full;
   assign wgt_en = pix_en & ~wgt_full;

   serial_loader #(
      .DEPTH (N_PIX),
      .CNT_W (PIX_CNT_W)
   ) u_pix_loader (
      .clk   (clk),
      .reset (reset),
      .en    (pix_en),
      .d_in  (d_in_p),
      .data  (pix_flat),
`ifdef REGISTERS_STATUS_EN
      .count (pixel_count),
`endif
      .full  (pix_full)
   );

`ifdef REGISTERS_STATUS_EN
   logic [WGT_CNT_W-1:0] wgt_count;
`endif

   serial_loader #(
      .DEPTH (N_WGT),
      .CNT_W (WGT_CNT_W)
   ) u_wgt_loader (
      .clk   (clk),
      .reset (reset),
      .en    (wgt_en),
      .d_in  (d_in_w),
      .data  (wgt_flat),
`ifdef REGISTERS_STATUS_EN
      .count (wgt_count),
`endif
      .full  (wgt_full)
   );

   assign pixels    = pix_flat;
   assign weights   = wgt_flat;
   assign load_done = pix_full;

`ifdef REGISTERS_STATUS_EN
   assign weights_done = wgt_full & (wgt_count == WGT_CNT_W'(N_WGT));
`endif

endmodule

// File: tb/tb_bnn_registers.sv
// Directed bench for bnn_registers: pattern loads, gaps, post-done freeze, mid-load reset.
module tb_bnn_registers;
   import bnn_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en_wr;
   logic                 d_in_p;
   logic                 d_in_w;
   pixel_img_t           pixels;
   kernel_t [N_FILT-1:0] weights;
   logic                 load_done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bnn_registers dut (
      .clk       (clk),
      .reset     (reset),
      .en_wr     (en_wr),
      .d_in_p    (d_in_p),
      .d_in_w    (d_in_w),
      .pixels    (pixels),
      .weights   (weights),
      .load_done (load_done)
   );

   task automatic check(input string tag, input logic [N_PIX-1:0] got,
                        input logic [N_PIX-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // mode 0: checkerboard, mode 1: all ones
   function automatic logic pix_bit(input int mode, input int k);
      if (mode == 1) return 1'b1;
      return (((k / 28) + (k % 28)) % 2) == 1;
   endfunction

   // mode 0: checkerboard then 0, mode 1: all 0, mode 2: checkerboard then 1
   function automatic logic wgt_bit(input int mode, input int k);
      if (k >= 72) return (mode == 2);
      if (mode == 1) return 1'b0;
      return (((k / 9) + ((k % 9) / 3) + (k % 3)) % 2) == 1;
   endfunction

   function automatic logic [N_PIX-1:0] exp_pix(input int mode);
      logic [N_PIX-1:0] v;
      v = '0;
      for (int k = 0; k < 784; k++) v[k] = pix_bit(mode, k);
      return v;
   endfunction

   function automatic logic [N_PIX-1:0] exp_wgt(input int mode);
      logic [N_PIX-1:0] v;
      v = '0;
      for (int k = 0; k < 72; k++) v[k] = wgt_bit(mode, k);
      return v;
   endfunction

   task automatic do_reset();
      en_wr  = 1'b0;
      d_in_p = 1'b0;
      d_in_w = 1'b0;
      reset  = 1'b1;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic load(input int pmode, input int wmode, input int gap_at,
                       input int gap_len, input int stop_at);
      for (int k = 0; k < stop_at; k++) begin
         if (k == gap_at) begin
            en_wr  = 1'b0;
            d_in_p = 1'b1;
            d_in_w = 1'b1;
            repeat (gap_len) @(posedge clk);
            #1;
            check("done_in_gap", N_PIX'(load_done), N_PIX'(1'b0));
         end
         if (k == 783) check("done_early", N_PIX'(load_done), N_PIX'(1'b0));
         en_wr  = 1'b1;
         d_in_p = pix_bit(pmode, k);
         d_in_w = wgt_bit(wmode, k);
         @(posedge clk);
         #1;
      end
      en_wr  = 1'b0;
      d_in_p = 1'b0;
      d_in_w = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      en_wr  = 1'b0;
      d_in_p = 1'b0;
      d_in_w = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check("rst_done", N_PIX'(load_done), N_PIX'(1'b0));
      check("rst_pix", N_PIX'(pixels), '0);
      check("rst_wgt", N_PIX'(weights), '0);

      // Checkerboard load followed by idle enabled cycles
      load(0, 0, -1, 0, 784);
      en_wr = 1'b1;
      repeat (10) @(posedge clk);
      #1 en_wr = 1'b0;
      check("t1_pix", N_PIX'(pixels), exp_pix(0));
      check("t1_wgt", N_PIX'(weights), exp_wgt(0));
      check("t1_done", N_PIX'(load_done), N_PIX'(1'b1));

      // All-ones pixels, zero weights, then disturbing traffic after done
      do_reset();
      load(1, 1, -1, 0, 784);
      check("t2_done", N_PIX'(load_done), N_PIX'(1'b1));
      en_wr  = 1'b1;
      d_in_p = 1'b0;
      d_in_w = 1'b1;
      repeat (10) @(posedge clk);
      #1 en_wr = 1'b0;
      check("t2_pix", N_PIX'(pixels), exp_pix(1));
      check("t2_wgt", N_PIX'(weights), '0);
      check("t2_done_hold", N_PIX'(load_done), N_PIX'(1'b1));

      // Disabled writes are ignored; first enabled bit is visible the next cycle
      do_reset();
      d_in_p = 1'b1;
      d_in_w = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("t3_pix00", N_PIX'(pixels[0][0]), N_PIX'(1'b0));
      check("t3_wgt000", N_PIX'(weights[0][0][0]), N_PIX'(1'b0));
      check("t3_done", N_PIX'(load_done), N_PIX'(1'b0));
      en_wr = 1'b1;
      @(posedge clk);
      #1 en_wr = 1'b0;
      check("t3_pix_first", N_PIX'(pixels), N_PIX'(1'b1));
      check("t3_wgt_first", N_PIX'(weights), N_PIX'(1'b1));

      // Gap of 20 cycles at bit 50; weight stream driven high after saturation
      do_reset();
      load(0, 2, 50, 20, 784);
      check("t4_pix", N_PIX'(pixels), exp_pix(0));
      check("t4_wgt", N_PIX'(weights), exp_wgt(0));
      check("t4_done", N_PIX'(load_done), N_PIX'(1'b1));

      // Reset at bit 400, then a full reload
      do_reset();
      load(0, 0, -1, 0, 400);
      check("t5_partial_pix01", N_PIX'(pixels[0][1]), N_PIX'(1'b1));
      reset = 1'b1;
      #1;
      check("t5_clr_pix", N_PIX'(pixels), '0);
      check("t5_clr_wgt", N_PIX'(weights), '0);
      check("t5_clr_done", N_PIX'(load_done), N_PIX'(1'b0));
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      load(0, 0, -1, 0, 784);
      check("t5_pix", N_PIX'(pixels), exp_pix(0));
      check("t5_wgt", N_PIX'(weights), exp_wgt(0));
      check("t5_done", N_PIX'(load_done), N_PIX'(1'b1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
